// File: rtl/tlul_pkg.sv
// Shared TL-UL definitions: field widths, opcodes, packed bus layouts and the
// response-state encoding used by the register adapter.
package tlul_pkg;

  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned AIW = 8;
  localparam int unsigned DIW = 1;
  localparam int unsigned DUW = 16;
  localparam int unsigned DBW = DW / 8;
  localparam int unsigned SZW = 2;

  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  localparam int unsigned H2D_W = 102;
  localparam int unsigned D2H_W = 68;

  // LSB offsets of each field inside the packed buses
  localparam int unsigned H2D_A_VALID   = 101;
  localparam int unsigned H2D_A_OPCODE  = 98;
  localparam int unsigned H2D_A_PARAM   = 95;
  localparam int unsigned H2D_A_SIZE    = 93;
  localparam int unsigned H2D_A_SOURCE  = 85;
  localparam int unsigned H2D_A_ADDRESS = 53;
  localparam int unsigned H2D_A_MASK    = 49;
  localparam int unsigned H2D_A_DATA    = 17;
  localparam int unsigned H2D_A_USER    = 1;
  localparam int unsigned H2D_D_READY   = 0;

  localparam int unsigned D2H_D_VALID   = 67;
  localparam int unsigned D2H_D_OPCODE  = 64;
  localparam int unsigned D2H_D_PARAM   = 61;
  localparam int unsigned D2H_D_SIZE    = 59;
  localparam int unsigned D2H_D_SOURCE  = 51;
  localparam int unsigned D2H_D_SINK    = 50;
  localparam int unsigned D2H_D_DATA    = 18;
  localparam int unsigned D2H_D_USER    = 2;
  localparam int unsigned D2H_D_ERROR   = 1;
  localparam int unsigned D2H_A_READY   = 0;

  typedef struct packed {
    logic             a_valid;
    logic [2:0]       a_opcode;
    logic [2:0]       a_param;
    logic [SZW-1:0]   a_size;
    logic [AIW-1:0]   a_source;
    logic [AW-1:0]    a_address;
    logic [DBW-1:0]   a_mask;
    logic [DW-1:0]    a_data;
    logic [DUW-1:0]   a_user;
    logic             d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic             d_valid;
    logic [2:0]       d_opcode;
    logic [2:0]       d_param;
    logic [SZW-1:0]   d_size;
    logic [AIW-1:0]   d_source;
    logic [DIW-1:0]   d_sink;
    logic [DW-1:0]    d_data;
    logic [DUW-1:0]   d_user;
    logic             d_error;
    logic             a_ready;
  } tl_d2h_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } rsp_state_e;

endpackage

// File: rtl/tlul_reg_adapter_if.sv
// Device-side TL-UL bus pair: host-to-device request and device-to-host response.
interface tlul_reg_adapter_if;
  import tlul_pkg::*;

  tl_h2d_t tl_h2d;
  tl_d2h_t tl_d2h;

  modport master (output tl_h2d, input tl_d2h);
  modport slave  (input tl_h2d, output tl_d2h);

endinterface

// File: rtl/tlul_reg_adapter.sv
// TL-UL endpoint turning each A request into a one-cycle register strobe and
// returning one registered D response; at most one response outstanding.
module tlul_reg_adapter
  import tlul_pkg::*;
#(
  parameter int unsigned RegAw = 8,
  parameter int unsigned RegDw = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  tlul_reg_adapter_if.slave    tl,
  output logic                 re_o,
  output logic                 we_o,
  output logic [RegAw-1:0]     addr_o,
  output logic [RegDw-1:0]     wdata_o,
  output logic [3:0]           be_o,
  input  logic [RegDw-1:0]     rdata_i,
  input  logic                 error_i
);

  tl_h2d_t    h2d;
  tl_d2h_t    d2h;
  rsp_state_e state_q, state_d;

  logic a_ready, d_valid, a_fire, d_fire;
  logic is_get, is_put, err_req, rsp_err;

  logic [2:0]       d_opcode_q;
  logic [SZW-1:0]   d_size_q;
  logic [AIW-1:0]   d_source_q;
  logic [DW-1:0]    d_data_q;
  logic             d_error_q;

  logic unused_h2d;

  assign h2d        = tl.tl_h2d;
  assign unused_h2d = ^{h2d.a_param, h2d.a_user};

  always_comb begin
    is_get  = (h2d.a_opcode == Get);
    is_put  = (h2d.a_opcode == PutFullData) || (h2d.a_opcode == PutPartialData);
    err_req = !(is_get || is_put)
            || (h2d.a_address[1:0] != 2'b00)
            || ((h2d.a_address >> RegAw) != '0)
            || (h2d.a_size > 2'd2)
            || ((h2d.a_opcode == PutFullData) && (h2d.a_mask != 4'hF));
    rsp_err = err_req || error_i;
  end

  assign a_fire = h2d.a_valid && a_ready;
  assign d_fire = d_valid && h2d.d_ready;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (a_fire) state_d = ST_RESP;
      ST_RESP: if (d_fire && !a_fire) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State outputs: accept a new request whenever the slot is free or being drained
  always_comb begin
    d_valid = (state_q == ST_RESP);
    a_ready = (state_q == ST_IDLE) || h2d.d_ready;
  end

  // Response register; rdata_i only reaches tl_d2h through these flops
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
      d_error_q  <= 1'b0;
    end else if (a_fire) begin
      d_opcode_q <= is_get ? AccessAckData : AccessAck;
      d_size_q   <= h2d.a_size;
      d_source_q <= h2d.a_source;
      d_error_q  <= rsp_err;
      if (is_get) d_data_q <= rsp_err ? '1 : rdata_i;
      else        d_data_q <= '0;
    end
  end

  always_comb begin
    d2h          = '0;
    d2h.d_valid  = d_valid;
    d2h.d_opcode = d_opcode_q;
    d2h.d_size   = d_size_q;
    d2h.d_source = d_source_q;
    d2h.d_data   = d_data_q;
    d2h.d_error  = d_error_q;
    d2h.a_ready  = a_ready;
  end

  assign tl.tl_d2h = d2h;

  always_comb begin
    re_o    = a_fire && !err_req && is_get;
    we_o    = a_fire && !err_req && is_put;
    addr_o  = {h2d.a_address[RegAw-1:2], 2'b00};
    wdata_o = h2d.a_data;
    be_o    = h2d.a_mask;
  end

endmodule

// File: tb/tb_tlul_reg_adapter.sv
// Randomized scoreboard bench for tlul_reg_adapter: stimulus pushes expected
// responses, a negedge monitor pops and compares them as the D channel drains.
module tb_tlul_reg_adapter;

  localparam int unsigned RA = 8;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  logic        a_valid, dr;
  logic [2:0]  a_op, a_param;
  logic [1:0]  a_size;
  logic [7:0]  a_src;
  logic [31:0] a_addr, a_data;
  logic [3:0]  a_mask;
  logic [15:0] a_user;

  logic [101:0] h2d_v;
  logic [67:0]  d2h_v;

  logic          re, we, err_in;
  logic [RA-1:0] addr;
  logic [31:0]   wdata, rdata;
  logic [3:0]    be;

  assign h2d_v = {a_valid, a_op, a_param, a_size, a_src, a_addr, a_mask, a_data, a_user, dr};

  tlul_reg_adapter_if tl_bus();
  assign tl_bus.tl_h2d = h2d_v;
  assign d2h_v = tl_bus.tl_d2h;

  tlul_reg_adapter #(.RegAw(RA), .RegDw(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .tl      (tl_bus.slave),
    .re_o    (re),
    .we_o    (we),
    .addr_o  (addr),
    .wdata_o (wdata),
    .be_o    (be),
    .rdata_i (rdata),
    .error_i (err_in)
  );

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  size;
    logic [7:0]  src;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  rsp_t        sb[$];
  int unsigned n_chk = 0;
  int unsigned n_fail = 0;
  bit          mon_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [2:0] o, input logic [1:0] s,
                               input logic [31:0] a, input logic [3:0] m);
    bit op_ok;
    op_ok = (o == 3'd0) || (o == 3'd1) || (o == 3'd4);
    return op_ok && (a % 4 == 0) && (a < (32'd1 << RA)) && (s <= 2'd2)
           && !(o == 3'd0 && m != 4'hF);
  endfunction

  // Response monitor
  initial forever begin
    @(negedge clk);
    if (mon_on) begin
      chk("d_valid", 64'(d2h_v[67]), 64'(sb.size() != 0));
      if (d2h_v[67] && sb.size() != 0) begin
        chk("d_opcode", 64'(d2h_v[66:64]), 64'(sb[0].op));
        chk("d_size",   64'(d2h_v[60:59]), 64'(sb[0].size));
        chk("d_source", 64'(d2h_v[58:51]), 64'(sb[0].src));
        chk("d_data",   64'(d2h_v[49:18]), 64'(sb[0].data));
        chk("d_error",  64'(d2h_v[1]),     64'(sb[0].err));
        chk("d_zero_fields", 64'({d2h_v[63:61], d2h_v[50], d2h_v[17:2]}), 64'd0);
        if (dr) sb.delete(0);
      end
    end
  end

  // mode 0: d_ready=1, mode 1: random d_ready, mode 2: d_ready=0 for 5 cycles then 1
  task automatic issue(input logic [2:0] o, input logic [1:0] s, input logic [7:0] src,
                       input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                       input logic [31:0] rd, input logic ei, input int mode);
    bit   acc, ok, exp_rdy;
    rsp_t e;
    acc = 1'b0;
    ok  = legal(o, s, a, m);
    a_valid = 1'b1; a_op = o; a_size = s; a_src = src; a_addr = a; a_mask = m; a_data = d;
    rdata = rd; err_in = ei;
    for (int w = 0; w < 40 && !acc; w++) begin
      if (mode == 1)      dr = 1'($urandom_range(0, 1));
      else if (mode == 2) dr = (w >= 5);
      else                dr = 1'b1;
      @(negedge clk); #1;
      exp_rdy = (sb.size() == 0) || dr;
      chk("a_ready", 64'(d2h_v[0]), 64'(exp_rdy));
      if (exp_rdy) begin
        chk("re_o", 64'(re), 64'(ok && o == 3'd4));
        chk("we_o", 64'(we), 64'(ok && (o == 3'd0 || o == 3'd1)));
        if (ok) begin
          chk("addr_o",  64'(addr),  64'(a % (32'd1 << RA)));
          chk("wdata_o", 64'(wdata), 64'(d));
          chk("be_o",    64'(be),    64'(m));
        end
        e.op   = (o == 3'd4) ? 3'd1 : 3'd0;
        e.size = s;
        e.src  = src;
        e.err  = !ok || ei;
        e.data = (o == 3'd4) ? (e.err ? 32'hFFFF_FFFF : rd) : 32'd0;
        sb.push_back(e);
        acc = 1'b1;
      end else begin
        chk("re_stalled", 64'(re), 64'd0);
        chk("we_stalled", 64'(we), 64'd0);
      end
      @(posedge clk); #1;
    end
    if (!acc) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout: got no a_ready expected accept within 40 cycles");
    end
    a_valid = 1'b0;
    err_in  = 1'b0;
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      if (rnd) dr = 1'($urandom_range(0, 1));
      @(negedge clk); #1;
      chk("re_idle", 64'(re), 64'd0);
      chk("we_idle", 64'(we), 64'd0);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    a_valid = 1'b0; a_op = '0; a_param = '0; a_size = '0; a_src = '0;
    a_addr = '0; a_mask = '0; a_data = '0; a_user = '0; dr = 1'b0;
    rdata = '0; err_in = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    @(negedge clk); #1;
    chk("rst_tl_o",    64'(d2h_v), 64'h1);
    chk("rst_strobes", 64'({re, we}), 64'd0);
    chk("rst_reg_bus", 64'({addr, wdata, be}), 64'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    dr    = 1'b1;
  endtask

  initial begin
    logic [2:0]  o;
    logic [1:0]  s;
    logic [31:0] a;
    logic [3:0]  m;
    int unsigned r;

    do_reset();
    mon_on = 1'b1;

    issue(3'd4, 2'd2, 8'h5A, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
    issue(3'd1, 2'd2, 8'h21, 32'h04, 4'h3, 32'h1234_5678, 32'h0, 1'b0, 0);
    issue(3'd4, 2'd2, 8'h30, 32'h102, 4'hF, 32'h0, 32'h5555_AAAA, 1'b0, 0);
    issue(3'd3, 2'd2, 8'h31, 32'h08, 4'hF, 32'hCAFE_0000, 32'h0, 1'b0, 0);
    issue(3'd0, 2'd2, 8'h32, 32'h0C, 4'h7, 32'hCAFE_0001, 32'h0, 1'b0, 0);
    idle(2, 1'b0);

    issue(3'd4, 2'd2, 8'h40, 32'h20, 4'hF, 32'h0, 32'h0BAD_F00D, 1'b0, 0);
    issue(3'd0, 2'd2, 8'h41, 32'h24, 4'hF, 32'h7777_8888, 32'h0, 1'b0, 2);
    idle(2, 1'b0);

    for (int i = 0; i < 8; i++)
      issue(3'd4, 2'd2, 8'(8'h80 + i), 32'(i * 4), 4'hF, 32'h0, $urandom, (i == 2), 0);
    idle(2, 1'b0);

    issue(3'd4, 2'd2, 8'h99, 32'h30, 4'hF, 32'h0, 32'h1357_9BDF, 1'b0, 2);
    do_reset();
    issue(3'd4, 2'd2, 8'h9A, 32'h34, 4'hF, 32'h0, 32'h2468_ACE0, 1'b0, 0);
    idle(2, 1'b0);

    for (int k = 0; k < 150; k++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      o = 3'd4;
      else if (r < 6) o = 3'd1;
      else if (r < 8) o = 3'd0;
      else            o = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63)) * 4;
      s = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'd2;
      m = (o == 3'd0 && $urandom_range(0, 5) != 0) ? 4'hF : 4'($urandom_range(0, 15));
      a_param = 3'($urandom);
      a_user  = 16'($urandom);
      issue(o, s, 8'($urandom), a, m, $urandom, $urandom, ($urandom_range(0, 7) == 0), 1);
      idle(int'($urandom_range(0, 2)), 1'b1);
    end

    dr = 1'b1;
    for (int w = 0; w < 20 && sb.size() != 0; w++) begin
      @(posedge clk); #1;
    end
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tlul_reg_adapter.md
# tlul_reg_adapter

Device-side TL-UL endpoint that sits directly downstream of the request FIFO of an asynchronous TL-UL crossing. It consumes the device-side `tl_h2d` bus and produces `tl_d2h`. It converts each accepted A-channel request into a single-cycle register read or write strobe, and returns exactly one D-channel response per request. At most one request is outstanding, with full back-to-back throughput when the host keeps `d_ready` high.

## Interface
- `RegAw`, default 8: register address width in bytes; address bits at or above RegAw must be 0.
- `RegDw`, fixed 32: register data width, equal to TL_DW.
- `clk_i`  in  1: clock; all logic on the rising edge.
- `rst_i`  in  1: reset, synchronous and active-high.
- `tl_i`  in  102: packed h2d bus.
  - Field map: a_valid[101], a_opcode[100:98], a_param[97:95], a_size[94:93], a_source[92:85], a_address[84:53], a_mask[52:49], a_data[48:17], a_user[16:1], d_ready[0].
- `tl_o`  out  68: packed d2h bus.
  - Field map: d_valid[67], d_opcode[66:64], d_param[63:61], d_size[60:59], d_source[58:51], d_sink[50], d_data[49:18], d_user[17:2], d_error[1], a_ready[0].
- `re_o`  out  1: register read strobe, one cycle per read.
- `we_o`  out  1: register write strobe, one cycle per write.
- `addr_o`  out  RegAw: word-aligned byte address; bits [1:0] are always 0.
- `wdata_o`  out  32: write data.
- `be_o`  out  4: byte enables, equal to a_mask.
- `rdata_i`  in  1×32: read data, valid in the same cycle as `re_o`.
- `error_i`  in  1: register-file error, valid in the same cycle as `re_o` or `we_o`.

## Operation
- **A-channel handshake:** `a_fire = a_valid & a_ready`.
  - `a_ready = !rsp_pending | d_ready`. A new request is accepted in the same cycle the previous response is consumed.
- **Request checks.** These are evaluated combinationally on the A fields. Any failure sets `err_req`:
  - a_opcode not in {PutFullData=0, PutPartialData=1, Get=4}
  - a_address[1:0] != 0
  - a_address[31:RegAw] != 0
  - a_size > 2
  - PutFullData with a_mask != 4'hF
- **Register strobes.**
  - On `a_fire & !err_req`: Get drives `re_o=1`; a Put drives `we_o=1`.
  - `addr_o = {a_address[RegAw-1:2], 2'b00}`, `wdata_o = a_data`, `be_o = a_mask`.
  - On `err_req` neither strobe asserts.
- **Response register.** Loaded on `a_fire`:
  - `d_opcode`: AccessAckData (1) for Get; AccessAck (0) for Put and for illegal opcodes.
  - `d_size = a_size`, `d_source = a_source`.
  - `d_param`, `d_sink`, `d_user` are 0.
  - `d_error = err_req | error_i`.
  - `d_data`:
    - `rdata_i` for a successful Get.
    - 32'hFFFF_FFFF for a Get with an error.
    - 0 for Puts.
- **`rsp_pending` flag.** This flag is the FSM:
  - IDLE → RESP on `a_fire`.
  - RESP → IDLE on `d_fire & !a_fire`.
  - RESP → RESP on `d_fire & a_fire`, which reloads the response register.
  - RESP with `!d_ready` holds; `d_*` stays stable and `a_ready = 0`.
- `d_valid = rsp_pending`.

## Timing
- Reset (`rst_i=1` at an edge) clears `rsp_pending` and all response fields to 0.
- During and after reset, every output is 0 except `a_ready = 1`.
- Strobes are combinational from `a_fire`, so they are 0 whenever `a_valid = 0`.
- Latency: A accepted in cycle N gives `d_valid` in cycle N+1.
- Throughput: 1 request per cycle with `d_ready` held at 1.
- Backpressure: `d_valid` stays high and all `d_*` fields stay constant until `d_ready`.
  - No strobe asserts while stalled.
- Reset asserted mid-response drops `d_valid` on the next edge; the pending response is discarded.
- Signals are combinational from `tl_i` to `a_ready`, `re_o`, `we_o`, `addr_o`, `wdata_o` and `be_o`. There is no combinational path from `rdata_i` to `tl_o`.

## Structure
- A shared package `tlul_pkg` holds:
  - the TL field widths (AW, DW, AIW, DIW, DUW, DBW, SZW)
  - the opcode constants: PutFullData=0, PutPartialData=1, Get=4, AccessAck=0, AccessAckData=1
  - the packed h2d/d2h field offsets
- The block is a single module with no sub-module; the response register and its one-bit state do not justify a split.

## Test plan
- Get of 0x10 with `rdata_i` = 0xDEAD_BEEF, `d_ready` = 1:
  - `re_o` pulses in cycle N.
  - Cycle N+1 shows `d_valid=1`, `d_opcode=1`, `d_data=0xDEADBEEF`, `d_error=0`, and `d_source` echoed.
- PutPartialData to 0x04, mask 4'b0011, data 0x1234_5678:
  - `we_o=1`, `be_o=3`, `wdata_o=0x12345678`.
  - Response is AccessAck with `d_error=0`.
- Illegal requests, each expecting no strobe and `d_error=1`:
  - address 0x102 with RegAw=8 (misaligned and out of range)
  - opcode 3
  - PutFullData with mask 4'h7
  - Illegal Gets return `d_data` 0xFFFFFFFF.
- `d_ready` held at 0 for 5 cycles with `a_valid` held:
  - `a_ready=0` and `d_*` are stable.
  - Releasing `d_ready` completes the response and accepts the next request in the same cycle.
- 8 back-to-back Gets with `d_ready` = 1:
  - 8 `re_o` pulses in 8 consecutive cycles.
  - 8 responses in order.
  - `error_i` pulsed on the 3rd request gives `d_error` only on the 3rd response.
- Reset asserted while `d_valid=1` and `d_ready=0`:
  - Next cycle `d_valid=0` and `a_ready=1`.
  - The first request after reset responds normally.
